// File: rtl/pair_alu.sv
// Two-operand streaming ALU: pairs consecutive input words (first, second) and
// registers one result per pair. Define PAIR_ALU_SAT_EN to clamp ADD/SUB results.
module pair_alu #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_gt,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [1:0] OP_AUTO = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_MAX  = 2'd3;

    state_t       state;
    logic [W-1:0] first_q;
    logic         accept;
    logic         consume;

    logic [W:0]   sum;
    logic [W:0]   diff;
    logic         gt;
    logic         use_add;
    logic [W-1:0] res;
    logic         carry;

    // A word may enter in the same cycle the held result drains.
    assign in_ready = (state != FULL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        sum     = {1'b0, first_q} + {1'b0, in_data};
        diff    = {1'b0, first_q} - {1'b0, in_data};
        gt      = in_data > first_q;
        use_add = (op == OP_ADD) || ((op == OP_AUTO) && gt);
        res     = '0;
        carry   = 1'b0;
        if (op == OP_MAX) begin
            res   = gt ? in_data : first_q;
            carry = 1'b0;
        end else if (use_add) begin
            carry = sum[W];
            res   = sum[W-1:0];
`ifdef PAIR_ALU_SAT_EN
            if (sum[W]) res = '1;
`endif
        end else begin
            // The extra top bit of the widened difference is the borrow (first < second).
            carry = diff[W];
            res   = diff[W-1:0];
`ifdef PAIR_ALU_SAT_EN
            if (diff[W]) res = '0;
`endif
        end
    end

    // NOTE: first_q is a plain data register with no reset; state alone says whether it holds a live operand.
    always_ff @(posedge clock) begin
        if (accept && (state != HALF)) first_q <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_gt    <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            if (consume) pair_cnt <= pair_cnt + CNT_W'(1);
            case (state)
                EMPTY: begin
                    if (accept) state <= HALF;
                end
                HALF: begin
                    if (accept) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_data  <= res;
                        out_carry <= carry;
                        out_zero  <= (res == '0);
                        out_gt    <= gt;
                    end
                end
                FULL: begin
                    // Result fields stay as they are after draining; only out_valid drops.
                    if (consume) begin
                        out_valid <= 1'b0;
                        state     <= accept ? HALF : EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pair_alu.sv
// Randomised scoreboard bench for pair_alu (W=8, CNT_W=16) plus a directed
// W=4, CNT_W=2 instance for narrow-width and counter-wrap behaviour.
module tb_pair_alu;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_carry;
    logic             out_zero;
    logic             out_gt;
    logic [CNT_W-1:0] pair_cnt;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0] s_in_data, s_out_data;
    logic [1:0] s_op, s_pair_cnt;
    logic       s_out_carry, s_out_zero, s_out_gt;

    pair_alu #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_carry(out_carry), .out_zero(out_zero),
        .out_gt(out_gt), .pair_cnt(pair_cnt)
    );

    pair_alu #(.W(4), .CNT_W(2)) u_small (
        .clock(clock), .reset(reset), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .op(s_op), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_carry(s_out_carry), .out_zero(s_out_zero),
        .out_gt(s_out_gt), .pair_cnt(s_pair_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        logic         gt;
    } exp_t;

    exp_t             sb[$];
    int               compared   = 0;
    int               mismatched = 0;
    logic [CNT_W-1:0] exp_cnt    = '0;
    bit               half       = 1'b0;
    logic [W-1:0]     first_w    = '0;
    bit               rnd_ready  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int a, input int b, input int o);
        exp_t e;
        int   maxv = (1 << W) - 1;
        int   r;
        bit   c;
        e.gt = (b > a);
        if (o == 3) begin
            r = (a > b) ? a : b;
            c = 1'b0;
        end else if (o == 1 || (o == 0 && b > a)) begin
            r = a + b;
            c = (r > maxv);
`ifdef PAIR_ALU_SAT_EN
            if (c) r = maxv;
`endif
        end else begin
            r = a - b;
            c = (a < b);
`ifdef PAIR_ALU_SAT_EN
            if (c) r = 0;
`endif
        end
        r      = r & maxv;
        e.data = r[W-1:0];
        e.carry = c;
        e.zero = (r == 0);
        return e;
    endfunction

    // Offer one word; returns one time unit after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [1:0] o);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        op       = o;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            mismatched++;
            compared++;
            $display("FAIL accept_timeout: word 0x%0h not accepted within %0d cycles", d, n);
        end else if (!half) begin
            first_w = d;
            half    = 1'b1;
        end else begin
            sb.push_back(model(first_w, d, o));
            half = 1'b0;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        op       = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (sb.size() != 0 || out_valid) begin
            mismatched++;
            compared++;
            $display("FAIL drain_timeout: %0d results still pending", sb.size());
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every consume and watches hold behaviour.
    initial begin
        exp_t       e;
        bit         have_prev = 1'b0;
        bit         prev_hold = 1'b0;
        logic [W-1:0] p_data;
        logic       p_carry, p_zero, p_gt;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_cnt   = '0;
                have_prev = 1'b0;
                continue;
            end
            check("pair_cnt", pair_cnt, exp_cnt);
            if (have_prev && prev_hold) begin
                check("hold_data", out_data, p_data);
                check("hold_carry", out_carry, p_carry);
                check("hold_zero", out_zero, p_zero);
                check("hold_gt", out_gt, p_gt);
                check("hold_valid", out_valid, 1);
            end
            if (out_valid && !out_ready) check("in_ready_backpressure", in_ready, 0);
            if (!out_valid) check("in_ready_idle", in_ready, 1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_result: out_data=0x%0h with nothing expected", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_carry", out_carry, e.carry);
                    check("out_zero", out_zero, e.zero);
                    check("out_gt", out_gt, e.gt);
                end
                exp_cnt = exp_cnt + CNT_W'(1);
            end
            have_prev = 1'b1;
            prev_hold = out_valid && !out_ready;
            p_data    = out_data;
            p_carry   = out_carry;
            p_zero    = out_zero;
            p_gt      = out_gt;
        end
    end

    task automatic s_word(input logic [3:0] d, input logic [1:0] o);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_op       = o;
        @(posedge clock);
        #1;
        s_in_valid = 1'b0;
        s_op       = 2'($urandom_range(0, 3));
    endtask

    task automatic s_pair(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                          input logic [3:0] exp_d, input logic exp_c, input logic [1:0] exp_n);
        s_word(a, 2'($urandom_range(0, 3)));
        s_word(b, o);
        @(negedge clock);
        check("small_valid", s_out_valid, 1);
        check("small_data", s_out_data, exp_d);
        check("small_carry", s_out_carry, exp_c);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("small_pair_cnt", s_pair_cnt, exp_n);
        check("small_drained", s_out_valid, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        op          = 2'd0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_op        = 2'd0;
        s_out_ready = 1'b1;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_out_gt", out_gt, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end

        // A first operand held across reset must be discarded.
        out_ready = 1'b1;
        send(8'h10, 2'($urandom_range(0, 3)));
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        half  = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        send(8'h20, 2'd2);
        send(8'h05, 2'd0);
        drain();

        // AUTO directed cases, then saturating-boundary ADD and SUB.
        send(8'h03, 2'd3);  send(8'h07, 2'd0);
        send(8'h09, 2'd1);  send(8'h04, 2'd0);
        send(8'h06, 2'd2);  send(8'h06, 2'd0);
        send(8'hF0, 2'd0);  send(8'h20, 2'd1);
        send(8'h02, 2'd0);  send(8'h05, 2'd2);
        send(8'h3C, 2'd0);  send(8'hA5, 2'd3);
        drain();

        // Backpressure: result held, then drained while the next first word enters.
        out_ready = 1'b0;
        send(8'h40, 2'd0);
        send(8'h11, 2'd1);
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(8'h33, 2'd3);
        check("bp_consumed_same_cycle", out_valid, 0);
        send(8'h30, 2'd2);
        drain();

        // Randomised traffic with random consumer stalls and idle gaps.
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clock);
                #1;
            end
            send(8'($urandom), 2'($urandom_range(0, 3)));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        drain();

        // Narrow instance: MAX, overflow, underflow, equal AUTO; counter wraps after 4.
        s_pair(4'h3, 4'hC, 2'd3, 4'hC, 1'b0, 2'd1);
`ifdef PAIR_ALU_SAT_EN
        s_pair(4'h9, 4'h9, 2'd1, 4'hF, 1'b1, 2'd2);
        s_pair(4'h2, 4'h5, 2'd2, 4'h0, 1'b1, 2'd3);
`else
        s_pair(4'h9, 4'h9, 2'd1, 4'h2, 1'b1, 2'd2);
        s_pair(4'h2, 4'h5, 2'd2, 4'hD, 1'b1, 2'd3);
`endif
        s_pair(4'h4, 4'h4, 2'd0, 4'h0, 1'b0, 2'd0);
        check("small_zero_flag", s_out_zero, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
